// File: rtl/ir_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// ir_fetch_unit_pkg
// Shared definitions for the instruction fetch stage.
//   - FUNSEL_* : register function-select encoding used for the PC
//                (00 clear, 01 load, 10 decrement, 11 increment)
//   - fetch_state_e : fetch FSM states with a fixed 2-bit encoding
// ---------------------------------------------------------------------------
package ir_fetch_unit_pkg;

  localparam logic [1:0] FUNSEL_CLEAR = 2'b00;
  localparam logic [1:0] FUNSEL_LOAD  = 2'b01;
  localparam logic [1:0] FUNSEL_DEC   = 2'b10;
  localparam logic [1:0] FUNSEL_INC   = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH_L = 2'd1,
    FETCH_H = 2'd2,
    VALID   = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/ir_fetch_unit_pc_counter.sv
// ---------------------------------------------------------------------------
// pc_counter
// ADDR_W-bit program counter register with function select and enable.
// Arithmetic wraps modulo 2^ADDR_W with no carry/borrow flag.
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous active-high, clears the counter
//   en     : apply funsel this cycle; otherwise hold
//   funsel : 00 clear, 01 load d, 10 decrement, 11 increment
//   d      : load value
//   q      : current counter value
// ---------------------------------------------------------------------------
module pc_counter
  import ir_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic [1:0]        funsel,
  input  logic [ADDR_W-1:0] d,
  output logic [ADDR_W-1:0] q
);

  // Counter register; reset has priority over any function select.
  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      case (funsel)
        FUNSEL_CLEAR: q <= '0;
        FUNSEL_LOAD:  q <= d;
        FUNSEL_DEC:   q <= q - ADDR_W'(1);
        FUNSEL_INC:   q <= q + ADDR_W'(1);
      endcase
    end
  end

endmodule

// File: rtl/ir_fetch_unit.sv
// ---------------------------------------------------------------------------
// ir_fetch_unit
// Fetches a 2*DATA_W-bit instruction as two consecutive bytes from a
// byte-wide memory (low byte at the lower address), assembles it into ir_q
// and offers it to the control unit with a valid/consume handshake.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   start        : request a fetch (sampled in IDLE and VALID)
//   pc_load      : load PC from pc_in (IDLE only)
//   pc_in        : PC load value
//   mem_req      : memory read request (FETCH_L / FETCH_H)
//   mem_addr     : read address, always equal to pc_q
//   mem_ack      : single-cycle acknowledge, mem_data valid with it
//   mem_data     : read data byte
//   ir_q         : assembled instruction
//   ir_valid     : ir_q holds a complete instruction
//   ir_consume   : control unit accepts ir_q (VALID only)
//   busy         : fetch in progress
//   pc_q         : current program counter
// ---------------------------------------------------------------------------
module ir_fetch_unit
  import ir_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                pc_load,
  input  logic [ADDR_W-1:0]   pc_in,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_data,
  output logic [2*DATA_W-1:0] ir_q,
  output logic                ir_valid,
  input  logic                ir_consume,
  output logic                busy,
  output logic [ADDR_W-1:0]   pc_q
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic         pc_en;
  logic [1:0]   pc_funsel;
  logic         ir_lo_we;
  logic         ir_hi_we;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control. mem_ack only matters in the two fetch
  // states, so acks arriving in IDLE or VALID are dropped here. A load that
  // coincides with start is committed this cycle, so FETCH_L sees the new PC.
  always_comb begin
    state_d   = state_q;
    pc_en     = 1'b0;
    pc_funsel = FUNSEL_INC;
    ir_lo_we  = 1'b0;
    ir_hi_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pc_load) begin
          pc_en     = 1'b1;
          pc_funsel = FUNSEL_LOAD;
        end
        if (start) begin
          state_d = FETCH_L;
        end
      end
      FETCH_L: begin
        if (mem_ack) begin
          ir_lo_we  = 1'b1;
          pc_en     = 1'b1;
          pc_funsel = FUNSEL_INC;
          state_d   = FETCH_H;
        end
      end
      FETCH_H: begin
        if (mem_ack) begin
          ir_hi_we  = 1'b1;
          pc_en     = 1'b1;
          pc_funsel = FUNSEL_INC;
          state_d   = VALID;
        end
      end
      VALID: begin
        if (ir_consume) begin
          state_d = start ? FETCH_L : IDLE;
        end
      end
    endcase
  end

  // Instruction register byte lanes, written only on accepted acks.
  always_ff @(posedge clock) begin
    if (reset) begin
      ir_q <= '0;
    end else begin
      if (ir_lo_we) begin
        ir_q[DATA_W-1:0] <= mem_data;
      end
      if (ir_hi_we) begin
        ir_q[2*DATA_W-1:DATA_W] <= mem_data;
      end
    end
  end

  pc_counter #(
    .ADDR_W (ADDR_W)
  ) u_pc_counter (
    .clock  (clock),
    .reset  (reset),
    .en     (pc_en),
    .funsel (pc_funsel),
    .d      (pc_in),
    .q      (pc_q)
  );

  // Handshake outputs decode from state only, keeping mem_ack off any
  // combinational path to mem_req.
  assign mem_req  = (state_q == FETCH_L) || (state_q == FETCH_H);
  assign busy     = mem_req;
  assign ir_valid = (state_q == VALID);
  assign mem_addr = pc_q;

endmodule

// File: doc/ir_fetch_unit.md
Name: ir_fetch_unit

Overview:
- Upstream fetch stage feeding the instruction register and program counter of the datapath.
- Fetches a 16-bit instruction as two consecutive bytes from byte-wide memory over a req/ack handshake.
- Assembles the bytes into IR, low byte from the lower address.
- Presents IR with a valid/consume handshake to the control unit.
- Drives PC using the team's register function-select encoding: 00 clear, 01 load, 10 decrement, 11 increment.

Parameters:
ADDR_W, 8, width of PC and memory address
DATA_W, 8, memory data width; IR width is 2*DATA_W

Ports:
clock  in  1  single clock, all state updates on rising edge
reset  in  1  synchronous, active-high
start  in  1  request an instruction fetch; sampled in IDLE and VALID
pc_load  in  1  load PC from pc_in; honoured in IDLE only
pc_in  in  ADDR_W  PC load value
mem_req  out  1  memory read request
mem_addr  out  ADDR_W  read address, equals PC
mem_ack  in  1  single-cycle acknowledge; mem_data valid in the same cycle
mem_data  in  DATA_W  read data
ir_q  out  2*DATA_W  assembled instruction
ir_valid  out  1  ir_q holds a complete instruction
ir_consume  in  1  control unit accepts ir_q
busy  out  1  high in FETCH_L or FETCH_H
pc_q  out  ADDR_W  current PC

Behaviour:
- Reset (checked first, overrides all inputs):
  - state=IDLE; pc_q=0; ir_q=0.
  - mem_req=0, ir_valid=0, busy=0.
  - Reset asserted mid-fetch aborts the fetch: mem_req is 0 from the next cycle, and a coincident mem_ack is ignored.
- States: IDLE, FETCH_L, FETCH_H, VALID. Outputs are registered or decoded from state only; no combinational path from mem_ack to mem_req.
- IDLE:
  - pc_load=1: pc<=pc_in (funsel 01) and stay in IDLE.
  - pc_load=1 with start=1 in the same cycle: load PC, then go to FETCH_L; the fetch uses the new PC.
  - start=1 alone: go to FETCH_L.
- FETCH_L:
  - mem_req=1, mem_addr=pc_q.
  - On mem_ack: ir_q[DATA_W-1:0]<=mem_data; pc increments (funsel 11); go to FETCH_H.
  - ir_q[2*DATA_W-1:DATA_W] is unchanged.
- FETCH_H:
  - mem_req=1, mem_addr=pc_q (already incremented).
  - On mem_ack: ir_q[2*DATA_W-1:DATA_W]<=mem_data; pc increments; go to VALID.
- mem_req stays high across the FETCH_L to FETCH_H transition. The address change is the byte boundary.
- While waiting for mem_ack: mem_req and mem_addr hold steady; there is no timeout.
- VALID:
  - ir_valid=1; ir_q and pc_q are stable.
  - ir_consume=1 with start=1: go directly to FETCH_L (back-to-back fetch; ir_valid low next cycle).
  - ir_consume=1 with start=0: go to IDLE.
  - ir_consume=0: stay in VALID; start is ignored.
- Latency: ack-to-ack gaps of zero give ir_valid two cycles after entering FETCH_L, counting the cycle the second ack is accepted.
- Ignored inputs:
  - mem_ack in IDLE or VALID.
  - ir_consume outside VALID.
  - pc_load outside IDLE.
- ir_q changes only on accepted acks or reset. The low byte updates before ir_valid, so consumers use ir_q only when ir_valid=1.
- PC arithmetic is modulo 2^ADDR_W: 0xFF increments to 0x00 with no flag. A fetch at 0xFF reads the low byte from 0xFF and the high byte from 0x00.
- Decrement (funsel 10) and clear (00) encodings are defined for PC but unused by this FSM. Clear occurs only on reset.

Decomposition:
- Shared package:
  - funsel constants FUNSEL_CLEAR=2'b00, FUNSEL_LOAD=2'b01, FUNSEL_DEC=2'b10, FUNSEL_INC=2'b11.
  - fetch state enum with 2-bit encoding IDLE=0, FETCH_L=1, FETCH_H=2, VALID=3.
- Natural sub-module: pc_counter. ADDR_W-bit register with funsel and enable, driven by the FSM.
- IR byte lanes stay inline.

Test Plan:
- Reset then idle: assert reset 2 cycles -> pc_q=0x00, ir_q=0x0000, mem_req=0, ir_valid=0, busy=0.
- Basic fetch:
  - Stimulus: mem[0x00]=0x34, mem[0x01]=0x12, start pulse, ack one cycle after each req.
  - Required: mem_addr 0x00 then 0x01; ir_q=0x1234; ir_valid=1; pc_q=0x02; held until ir_consume.
- Load and wrap:
  - Stimulus: pc_load with pc_in=0xFF, then start; mem[0xFF]=0xCD, mem[0x00]=0xAB.
  - Required: ir_q=0xABCD, pc_q=0x01.
- Stalled memory:
  - Stimulus: delay ack 5 cycles in FETCH_L and 3 cycles in FETCH_H.
  - Required: mem_req and mem_addr stable throughout; busy=1; result identical to the basic fetch case.
- Back-to-back fetch:
  - Stimulus: ir_consume and start together in VALID.
  - Required: FETCH_L next cycle at pc_q=0x02; ir_valid low; start while VALID without consume has no effect.
- Abort and ignore:
  - Stimulus: reset asserted in FETCH_H together with mem_ack.
  - Required: next cycle IDLE, pc_q=0, ir_q=0, mem_req=0.
  - Also required: mem_ack pulses and pc_load in VALID change nothing.
